bit_capture_sequencer: RTL and testbench

Controller that sequences the bit-select capture datapath. It snapshots an input word on a start request, then walks the bit-select code through all positions, one per cycle, in LSB-first or MSB-first order. Each selected bit is gated by a capture mask, and the assembled word is delivered on a valid/ready output handshake. It sits between the requesting logic and the bit-capture register. It drives the datapath's select code and its per-bit capture strobe.

---
 rtl/bit_capture_sequencer_if.sv | 31 +++
 rtl/bit_capture_sequencer.sv | 124 ++++++++++++
 tb/tb_bit_capture_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_capture_sequencer_if.sv
// Handshake and datapath-control bundle for the bit capture sequencer.
// master = requesting/consuming logic, slave = the sequencer itself.
interface bit_capture_sequencer_if #(
    parameter int WIDTH = 8
);
    localparam int SELW = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] mask;
    logic             msb_first;
    logic             abort;
    logic             out_ready;
    logic             clr_err;
    logic [SELW-1:0]  sel;
    logic             cap_en;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             start_drop;

    modport master (
        output start, in_data, mask, msb_first, abort, out_ready, clr_err,
        input  sel, cap_en, busy, out_valid, out_data, start_drop
    );

    modport slave (
        input  start, in_data, mask, msb_first, abort, out_ready, clr_err,
        output sel, cap_en, busy, out_valid, out_data, start_drop
    );
endinterface

// File: rtl/bit_capture_sequencer.sv
// Bit capture sequencer: snapshots a word on start, walks the bit-select
// code over every position (LSB- or MSB-first), gates each bit by the
// captured mask and presents the assembled word on a valid/ready output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; sel=0, cap_en=0, busy=0
// CAPTURE | one bit position per cycle, cnt runs 0..WIDTH-1
// DONE    | out_valid held with the assembled word until out_ready
module bit_capture_sequencer #(
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(WIDTH)
) (
    input logic                   clk,
    input logic                   rst,
    bit_capture_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [SELW-1:0] CNT_LAST = SELW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [SELW-1:0]  cnt;
    logic [WIDTH-1:0] snap_data;
    logic [WIDTH-1:0] snap_mask;
    logic             snap_msb;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] asm_nxt;
    logic [WIDTH-1:0] out_data_q;
    logic             drop_q;
    logic [SELW-1:0]  sel_c;
    logic             cap_en_c;
    logic             busy_c;
    logic             last_c;

    // Next-state decode plus the select/strobe outputs derived from registered state.
    always_comb begin
        state_nxt = state;
        sel_c     = '0;
        cap_en_c  = 1'b0;
        busy_c    = 1'b0;
        last_c    = 1'b0;
        asm_nxt   = asm_q;
        case (state)
            ST_IDLE: begin
                if (bus.start) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                busy_c   = 1'b1;
                sel_c    = snap_msb ? (CNT_LAST - cnt) : cnt;
                cap_en_c = snap_mask[sel_c];
                last_c   = (cnt == CNT_LAST);
                if (cap_en_c) asm_nxt[sel_c] = snap_data[sel_c];
                // abort outranks the final-bit transition
                if (bus.abort)   state_nxt = ST_IDLE;
                else if (last_c) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy_c = 1'b1;
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, walk counter, input snapshot and word assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            snap_data  <= '0;
            snap_mask  <= '0;
            snap_msb   <= 1'b0;
            asm_q      <= '0;
            out_data_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        snap_data <= bus.in_data;
                        snap_mask <= bus.mask;
                        snap_msb  <= bus.msb_first;
                        asm_q     <= '0;
                        cnt       <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.abort) begin
                        asm_q <= '0;
                        cnt   <= '0;
                    end else begin
                        asm_q <= asm_nxt;
                        cnt   <= last_c ? '0 : cnt + SELW'(1);
                        // out_data only moves when a complete word is ready,
                        // so it keeps the last result across IDLE and aborts
                        if (last_c) out_data_q <= asm_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky flag for start requests that arrive while not idle; a new drop beats clr_err.
    always_ff @(posedge clk) begin
        if (rst)                                drop_q <= 1'b0;
        else if (bus.start && state != ST_IDLE) drop_q <= 1'b1;
        else if (bus.clr_err)                   drop_q <= 1'b0;
    end

    assign bus.sel        = sel_c;
    assign bus.cap_en     = cap_en_c;
    assign bus.busy       = busy_c;
    assign bus.out_valid  = (state == ST_DONE);
    assign bus.out_data   = out_data_q;
    assign bus.start_drop = drop_q;

endmodule

// File: tb/tb_bit_capture_sequencer.sv
// Bench for bit_capture_sequencer: vector table, hand-written corner
// sequences and randomized captures against a word-level reference model.
module tb_bit_capture_sequencer;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    bit_capture_sequencer_if #(.WIDTH(WIDTH)) bus ();

    bit_capture_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] mask;
        logic       msb;
        int         abort_at;
        int         rdelay;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Order in which bit positions are visited.
    function automatic void walk_order(input logic msb, output int order [WIDTH]);
        for (int k = 0; k < WIDTH; k++) order[k] = msb ? (WIDTH - 1 - k) : k;
    endfunction

    // Word the consumer should receive: visit each position, keep the bit if masked.
    function automatic logic [7:0] model_word(input logic [7:0] data, input logic [7:0] mask,
                                              input logic msb);
        int         order [WIDTH];
        logic [7:0] w;
        w = '0;
        walk_order(msb, order);
        foreach (order[k]) if (mask[order[k]]) w[order[k]] = data[order[k]];
        return w;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sel"},   32'(bus.sel), 0);
        chk({tag, "_cap"},   32'(bus.cap_en), 0);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_data"},  32'(bus.out_data), 0);
        chk({tag, "_drop"},  32'(bus.start_drop), 0);
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 20; n++) begin
            if (bus.out_valid) break;
            tick();
        end
        chk({tag, "_wait_valid"}, 32'(bus.out_valid), 1);
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // One full capture: start, per-cycle sel/cap_en check, optional abort,
    // hold with out_ready low for rdelay cycles, then handshake.
    task automatic run_vec(input logic [7:0] data, input logic [7:0] mask, input logic msb,
                           input int abort_at, input int rdelay, input logic [7:0] exp,
                           input string tag);
        int   order [WIDTH];
        logic bad;
        walk_order(msb, order);
        bus.start     = 1'b1;
        bus.in_data   = data;
        bus.mask      = mask;
        bus.msb_first = msb;
        tick();
        bus.start     = 1'b0;
        bus.in_data   = ~data;
        bus.mask      = ~mask;
        bus.msb_first = ~msb;
        chk({tag, "_busy_start"}, 32'(bus.busy), 1);
        bad = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.sel !== 3'(order[i]) || bus.cap_en !== mask[order[i]] ||
                bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
                bad = 1'b1;
                $display("FAIL %s_walk cycle=%0d sel=%0d cap_en=%0b valid=%0b expected sel=%0d cap_en=%0b",
                         tag, i, bus.sel, bus.cap_en, bus.out_valid, order[i], mask[order[i]]);
            end
            if (i == abort_at) begin
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                chk({tag, "_walk_ok"}, 32'(bad), 0);
                chk({tag, "_abort_busy"}, 32'(bus.busy), 0);
                chk({tag, "_abort_sel"}, 32'(bus.sel), 0);
                bad = 1'b0;
                for (int j = 0; j < WIDTH + 2; j++) begin
                    if (bus.out_valid !== 1'b0) bad = 1'b1;
                    tick();
                end
                chk({tag, "_abort_no_valid"}, 32'(bad), 0);
                return;
            end
            tick();
        end
        chk({tag, "_walk_ok"}, 32'(bad), 0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
        chk({tag, "_done_sel_cap"}, {bus.sel, bus.cap_en}, 0);
        bad = 1'b0;
        for (int j = 0; j < rdelay; j++) begin
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp) bad = 1'b1;
        end
        chk({tag, "_hold_stable"}, 32'(bad), 0);
        handshake();
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 0);
        chk({tag, "_busy_end"}, 32'(bus.busy), 0);
        chk({tag, "_data_kept"}, 32'(bus.out_data), 32'(exp));
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'hFF, 1'b0, -1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 8'h0F, 1'b1, -1, 0, 8'h0C};
        vecs[2] = '{8'h5A, 8'hFF, 1'b0, -1, 5, 8'h5A};
        vecs[3] = '{8'hA5, 8'hFF, 1'b0,  3, 0, 8'h00};
        vecs[4] = '{8'h81, 8'hFF, 1'b0, -1, 0, 8'h81};
        vecs[5] = '{8'h77, 8'h00, 1'b1, -1, 1, 8'h00};
        vecs[6] = '{8'hF0, 8'hAA, 1'b1, -1, 2, 8'hA0};
        vecs[7] = '{8'hC3, 8'h3C, 1'b0, -1, 0, 8'h00};

        bus.start     = 1'b0;
        bus.in_data   = '0;
        bus.mask      = '0;
        bus.msb_first = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_err   = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        for (int v = 0; v < 8; v++)
            run_vec(vecs[v].data, vecs[v].mask, vecs[v].msb, vecs[v].abort_at,
                    vecs[v].rdelay, vecs[v].exp, $sformatf("vec%0d", v));

        // start during CAPTURE and during DONE are dropped and flagged
        bus.start = 1'b1; bus.in_data = 8'h5A; bus.mask = 8'hFF; bus.msb_first = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1; bus.in_data = 8'h00; bus.mask = 8'h00; bus.msb_first = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("drop_in_capture", 32'(bus.start_drop), 1);
        wait_valid("drop");
        chk("drop_result", 32'(bus.out_data), 32'h5A);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("drop_done_valid", 32'(bus.out_valid), 1);
        chk("drop_done_data", 32'(bus.out_data), 32'h5A);
        tick();
        chk("drop_held", 32'(bus.start_drop), 1);
        handshake();
        chk("drop_after_hs_valid", 32'(bus.out_valid), 0);
        chk("drop_after_hs_flag", 32'(bus.start_drop), 1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("drop_cleared", 32'(bus.start_drop), 0);
        bus.start = 1'b1; bus.in_data = 8'h5A; bus.mask = 8'hFF;
        tick();
        bus.start = 1'b0;
        chk("drop_accept_no_flag", 32'(bus.start_drop), 0);
        bus.start = 1'b1; bus.clr_err = 1'b1;
        tick();
        bus.start = 1'b0; bus.clr_err = 1'b0;
        chk("drop_set_wins", 32'(bus.start_drop), 1);
        wait_valid("drop2");
        chk("drop2_result", 32'(bus.out_data), 32'h5A);
        handshake();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;

        // reset in CAPTURE at counter 5
        bus.start = 1'b1; bus.in_data = 8'hA5; bus.mask = 8'hFF; bus.msb_first = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("rst_cap_sel", 32'(bus.sel), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst_cap");

        // reset in DONE with out_ready low and start_drop set
        bus.start = 1'b1; bus.in_data = 8'hA5; bus.mask = 8'hFF;
        tick();
        bus.start = 1'b0;
        wait_valid("rst_done");
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("rst_done_drop_pre", 32'(bus.start_drop), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst_done");
        run_vec(8'hFF, 8'h00, 1'b0, -1, 0, 8'h00, "mask_zero");

        // randomized captures against the word-level model
        for (int r = 0; r < 24; r++) begin
            logic [7:0] d, m;
            logic       o;
            int         ab, rd;
            d  = 8'($urandom);
            m  = 8'($urandom);
            o  = 1'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1;
            rd = int'($urandom_range(0, 3));
            run_vec(d, m, o, ab, rd, model_word(d, m, o), $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
